// File: rtl/serial_capture_sipo_if.sv
// Serial capture bus: serial bit stream in, parallel word out with valid/ready.
interface serial_capture_sipo_if #(
  parameter int unsigned WIDTH = 5
);
  logic             start;
  logic             din_valid;
  logic             D;
  logic             ready;
  logic [WIDTH-1:0] vec_out;
  logic             valid;
  logic             busy;
  logic             overrun;

  modport master (
    output start, din_valid, D, ready,
    input  vec_out, valid, busy, overrun
  );

  modport slave (
    input  start, din_valid, D, ready,
    output vec_out, valid, busy, overrun
  );
endinterface

// File: rtl/serial_capture_sipo.sv
// Serial-in/parallel-out receiver: first bit received lands in vec_out[0].
// Completed words are held until consumed; words arriving while one is pending are dropped.
module serial_capture_sipo #(
  parameter int unsigned WIDTH = 5
) (
  input logic                   clk,
  input logic                   clr,
  serial_capture_sipo_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]   vec_q, vec_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               ovr_q, ovr_d;
  logic [WIDTH-1:0]   word;
  logic               complete;

  assign word = {bus.D, sr_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      vec_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      vec_q   <= vec_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state, shift path and output-register update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    vec_d    = vec_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      SHIFT: begin
        // start resynchronises and outranks a coincident data bit
        if (bus.start) begin
          cnt_d = '0;
          sr_d  = '0;
        end else if (bus.din_valid) begin
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
            sr_d     = '0;
          end else begin
            sr_d  = word;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      if (!valid_q || bus.ready) begin
        vec_d   = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d == SHIFT);
  end

  assign bus.vec_out = vec_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = ovr_q;
endmodule

// File: tb/tb_serial_capture_sipo.sv
// Directed self-checking bench for serial_capture_sipo (WIDTH=5).
module tb_serial_capture_sipo;
  localparam int unsigned WIDTH = 5;

  logic clk = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_errors = 0;

  serial_capture_sipo_if #(.WIDTH(WIDTH)) bus ();

  serial_capture_sipo #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge; outputs are then sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.din_valid = 1'b1;
    bus.D         = b;
    tick();
    bus.din_valid = 1'b0;
    bus.D         = 1'b0;
  endtask

  task automatic send_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // bits go out LSB first so w[i] is the i-th bit received
  task automatic send_word(input logic [WIDTH-1:0] w);
    send_start();
    for (int i = 0; i < int'(WIDTH); i++) send_bit(w[i]);
  endtask

  task automatic consume();
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    clr           = 1'b1;
    bus.start     = 1'b0;
    bus.din_valid = 1'b0;
    bus.D         = 1'b0;
    bus.ready     = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    check("rst_vec", 32'(bus.vec_out), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_ovr", 32'(bus.overrun), 32'h0);

    // basic word: bits 0,1,1,0,1
    send_start();
    check("t1_busy_start", 32'(bus.busy), 32'h1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check("t1_valid_pre", 32'(bus.valid), 32'h0);
    send_bit(1'b1);
    check("t1_valid", 32'(bus.valid), 32'h1);
    check("t1_vec", 32'(bus.vec_out), 32'h16);
    check("t1_busy_done", 32'(bus.busy), 32'h0);
    consume();
    check("t1_consumed", 32'(bus.valid), 32'h0);
    check("t1_vec_hold", 32'(bus.vec_out), 32'h16);

    // same word with a 3-cycle gap between bits 2 and 3
    send_start();
    send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_busy_gap", 32'(bus.busy), 32'h1);
    end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("t2_valid", 32'(bus.valid), 32'h1);
    check("t2_vec", 32'(bus.vec_out), 32'h16);
    consume();

    // back-pressure: second word dropped
    send_word(5'b00011);
    check("t3_valid1", 32'(bus.valid), 32'h1);
    check("t3_vec1", 32'(bus.vec_out), 32'h03);
    check("t3_ovr0", 32'(bus.overrun), 32'h0);
    send_word(5'b10101);
    check("t3_ovr1", 32'(bus.overrun), 32'h1);
    check("t3_vec_kept", 32'(bus.vec_out), 32'h03);
    check("t3_valid_kept", 32'(bus.valid), 32'h1);
    consume();
    check("t3_consumed", 32'(bus.valid), 32'h0);
    check("t3_ovr_sticky", 32'(bus.overrun), 32'h1);
    tick();
    check("t3_ovr_sticky2", 32'(bus.overrun), 32'h1);
    do_clr();
    check("t3_ovr_clr", 32'(bus.overrun), 32'h0);

    // completion coincident with consume of a pending word
    send_word(5'b01110);
    check("t4_valid_a", 32'(bus.valid), 32'h1);
    send_start();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    check("t4_vec_a_held", 32'(bus.vec_out), 32'h0e);
    bus.ready = 1'b1;
    send_bit(1'b1);
    bus.ready = 1'b0;
    check("t4_valid_b", 32'(bus.valid), 32'h1);
    check("t4_vec_b", 32'(bus.vec_out), 32'h18);
    check("t4_ovr", 32'(bus.overrun), 32'h0);
    consume();
    check("t4_consumed", 32'(bus.valid), 32'h0);

    // resync: 3 bits, start with a coincident valid bit, then full word
    send_start();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    bus.start = 1'b1; bus.din_valid = 1'b1; bus.D = 1'b1;
    tick();
    bus.start = 1'b0; bus.din_valid = 1'b0; bus.D = 1'b0;
    check("t5_busy_resync", 32'(bus.busy), 32'h1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    check("t5_valid_pre", 32'(bus.valid), 32'h0);
    send_bit(1'b1);
    check("t5_valid", 32'(bus.valid), 32'h1);
    check("t5_vec", 32'(bus.vec_out), 32'h19);
    consume();

    // clr mid-word, then a full word
    send_start();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    do_clr();
    check("t6_clr_vec", 32'(bus.vec_out), 32'h0);
    check("t6_clr_valid", 32'(bus.valid), 32'h0);
    check("t6_clr_busy", 32'(bus.busy), 32'h0);
    check("t6_clr_ovr", 32'(bus.overrun), 32'h0);
    send_bit(1'b1); send_bit(1'b1);
    check("t6_idle_ignores", 32'(bus.valid), 32'h0);
    send_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("t6_valid_pre", 32'(bus.valid), 32'h0);
    send_bit(1'b0);
    check("t6_valid", 32'(bus.valid), 32'h1);
    check("t6_vec", 32'(bus.vec_out), 32'h0a);
    consume();
    check("t6_consumed", 32'(bus.valid), 32'h0);
    tick(); tick();
    check("t6_single_pulse", 32'(bus.valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
